// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a byte FIFO through its rd/dout/empty port and presents the words,
//   in order, on a valid/ready master stream. A 2-entry output buffer absorbs
//   the FIFO's one-cycle read latency so the stream sustains one word/cycle.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   en               allow new FIFO reads (buffered data drains regardless)
//   fifo_empty       FIFO empty flag
//   fifo_full        FIFO full flag
//   fifo_wr          copy of the FIFO write strobe (write beats read in the FIFO)
//   fifo_dout        FIFO read data, valid the cycle after an honored read
//   fifo_rd          FIFO read strobe (combinational)
//   m_valid/m_ready  output stream handshake
//   m_data           output word (buffer head)
//   xfer_cnt         count of completed output handshakes (wraps)
//
// Handshake: a word transfers on every rising edge where m_valid & m_ready.
// While m_valid is high and m_ready is low, m_valid and m_data hold steady.
module fifo_stream_reader #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic          fifo_wr,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] xfer_cnt
);

  // r_buf0 is always the head; r_buf1 holds the second word when r_occ = 2.
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [1:0]    r_occ;
  logic          r_pend;
  logic [CW-1:0] r_xfer_cnt;

  logic       w_deq;
  logic [2:0] w_fill;
  logic       w_honored;
  logic       w_tail_hi;

  assign w_deq = (r_occ != 2'd0) & m_ready;

  // Occupancy after this edge, counting the word already in flight. A pop
  // only happens with r_occ >= 1, so this never underflows.
  assign w_fill = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_deq};

  // Reading only while the post-edge fill stays below 2 keeps occ + pend <= 2,
  // so the buffer can never overflow. Gated by rst_n so it is low in reset.
  assign fifo_rd = rst_n & en & ~fifo_empty & (w_fill < 3'd2);

  // The FIFO ignores a read on a cycle where it accepts a write.
  assign w_honored = fifo_rd & ~(fifo_wr & ~fifo_full);

  // Slot the captured word lands in, after any pop this edge shifts the head.
  assign w_tail_hi = ((r_occ == 2'd1) & ~w_deq) | ((r_occ == 2'd2) & w_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= 2'd0;
      r_pend     <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_pend <= w_honored;
      r_occ  <= w_fill[1:0];
      if (w_deq) begin
        r_buf0     <= r_buf1;
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
      // Placed after the pop so a capture into slot 0 overrides the shift.
      if (r_pend) begin
        if (w_tail_hi) r_buf1 <= fifo_dout;
        else           r_buf0 <= fifo_dout;
      end
    end
  end

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf0;
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_wr = 1'b0;
  logic [DW-1:0] fifo_wdata = '0;

  logic          fifo_empty, fifo_full, fifo_rd, m_valid;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_cnt;

  logic          fifo_rd4, m_valid4;
  logic [DW-1:0] m_data4;
  logic [3:0]    xfer_cnt4;

  int checks = 0;
  int errors = 0;

  fifo_stream_reader #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .xfer_cnt(xfer_cnt)
  );

  // Narrow-counter copy on identical inputs; only the counter width differs.
  fifo_stream_reader #(.DW(DW), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .xfer_cnt(xfer_cnt4)
  );

  // ---------------- FIFO model (16 x 8, write beats read) ----------------
  logic [DW-1:0] f_mem [16];
  logic [3:0]    f_wp = '0;
  logic [3:0]    f_rp = '0;
  logic [4:0]    f_cnt = '0;

  assign fifo_empty = (f_cnt == 5'd0);
  assign fifo_full  = (f_cnt == 5'd16);

  always @(posedge clk) begin
    if (fifo_wr && f_cnt != 5'd16) begin
      f_mem[f_wp] <= fifo_wdata;
      f_wp        <= f_wp + 4'd1;
      f_cnt       <= f_cnt + 5'd1;
    end else if (fifo_rd && f_cnt != 5'd0) begin
      fifo_dout <= f_mem[f_rp];
      f_rp      <= f_rp + 4'd1;
      f_cnt     <= f_cnt - 5'd1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic [DW-1:0] exp_w;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (xfer_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL xfer_cnt: got %0d expected %0d", xfer_cnt, exp_cnt);
      end
      checks++;
      if (xfer_cnt4 !== exp_cnt[3:0]) begin
        errors++;
        $display("FAIL xfer_cnt_cw4: got %0d expected %0d", xfer_cnt4, exp_cnt[3:0]);
      end
      checks++;
      if ({fifo_rd4, m_valid4, m_data4} !== {fifo_rd, m_valid, m_data}) begin
        errors++;
        $display("FAIL cw4_copy: got %b/%b/%h expected %b/%b/%h",
                 fifo_rd4, m_valid4, m_data4, fifo_rd, m_valid, m_data);
      end
      checks++;
      if (int'(dut.r_occ) + int'(dut.r_pend) > 2) begin
        errors++;
        $display("FAIL occ_plus_pend: got %0d expected <= 2",
                 int'(dut.r_occ) + int'(dut.r_pend));
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h expected v=1 d=%h",
                   m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_data: got %h expected no word", m_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data !== exp_w) begin
            errors++;
            $display("FAIL stream_data: got %h expected %h", m_data, exp_w);
          end
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_wr(input logic [DW-1:0] d);
    fifo_wr    = 1'b1;
    fifo_wdata = d;
    exp_q.push_back(d);
    cyc(1);
    fifo_wr = 1'b0;
  endtask

  // Expected stream after a reset = whatever the FIFO still holds.
  task automatic sync_exp_q;
    logic [3:0] idx;
    exp_q.delete();
    for (int i = 0; i < int'(f_cnt); i++) begin
      idx = f_rp + 4'(i);
      exp_q.push_back(f_mem[idx]);
    end
  endtask

  task automatic do_reset;
    en      = 1'b0;
    m_ready = 1'b0;
    fifo_wr = 1'b0;
    rst_n   = 1'b0;
    cyc(2);
    sync_exp_q();
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_drain;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !m_valid && !dut.r_pend && f_cnt == 5'd0) done = 1'b1;
      else cyc(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    checks++;
    if ({m_valid, m_data, xfer_cnt, fifo_rd} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got v=%b d=%h c=%0d rd=%b expected all 0",
               m_valid, m_data, xfer_cnt, fifo_rd);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) drive_wr(8'hA0 + 8'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    cyc(4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, xfer_cnt, fifo_rd} !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h c=%0d rd=%b expected all 0",
               m_valid, m_data, xfer_cnt, fifo_rd);
    end
    checks++;
    if (dut.r_occ !== 2'd0 || dut.r_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got occ=%0d pend=%b expected 0/0", dut.r_occ, dut.r_pend);
    end
    sync_exp_q();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({m_valid, m_data, xfer_cnt, fifo_rd} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got v=%b d=%h c=%0d rd=%b expected all 0",
                 m_valid, m_data, xfer_cnt, fifo_rd);
      end
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_rd: got %b expected 1", fifo_rd);
    end
    wait_drain();
  endtask

  task automatic test_streaming;
    logic          rd_log [24];
    logic          v_log  [24];
    logic [DW-1:0] d_log  [24];
    do_reset();
    for (int i = 0; i < 16; i++) drive_wr(8'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      rd_log[c] = fifo_rd;
      v_log[c]  = m_valid;
      d_log[c]  = m_data;
    end
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (rd_log[c] !== (c < 16) || v_log[c] !== (c >= 2 && c < 18)) begin
        errors++;
        $display("FAIL stream_timing c=%0d: got rd=%b v=%b expected rd=%b v=%b",
                 c, rd_log[c], v_log[c], c < 16, c >= 2 && c < 18);
      end
      if (c >= 2 && c < 18) begin
        checks++;
        if (d_log[c] !== 8'(c - 2)) begin
          errors++;
          $display("FAIL stream_seq c=%0d: got %h expected %h", c, d_log[c], 8'(c - 2));
        end
      end
    end
    checks++;
    if (xfer_cnt !== 16'd16 || fifo_empty !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got c=%0d e=%b v=%b expected 16/1/0",
               xfer_cnt, fifo_empty, m_valid);
    end
    cyc(1);
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int i = 0; i < 8; i++) drive_wr(8'h20 + 8'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    cyc(4);
    m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h22) begin
        errors++;
        $display("FAIL bp_stall c=%0d: got rd=%b v=%b d=%h expected 0/1/22",
                 c, fifo_rd, m_valid, m_data);
      end
      if (c >= 1) begin
        checks++;
        if (dut.r_occ !== 2'd2) begin
          errors++;
          $display("FAIL bp_occ c=%0d: got %0d expected 2", c, dut.r_occ);
        end
      end
    end
    checks++;
    if (f_cnt !== 5'd4) begin
      errors++;
      $display("FAIL bp_fifo_count: got %0d expected 4", f_cnt);
    end
    cyc(1);
    m_ready = 1'b1;
    wait_drain();
    checks++;
    if (xfer_cnt !== 16'd8) begin
      errors++;
      $display("FAIL bp_total: got %0d expected 8", xfer_cnt);
    end
  endtask

  task automatic test_collision;
    do_reset();
    for (int i = 0; i < 6; i++) drive_wr(8'h40 + 8'(i));
    en         = 1'b1;
    m_ready    = 1'b1;
    fifo_wr    = 1'b1;
    fifo_wdata = 8'h46;
    exp_q.push_back(8'h46);
    @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL coll_rd: got %b expected 1", fifo_rd);
    end
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.r_pend !== 1'b0 || fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL coll_drop: got pend=%b rd=%b expected 0/1", dut.r_pend, fifo_rd);
    end
    @(negedge clk);
    checks++;
    if (dut.r_occ !== 2'd0 || m_valid !== 1'b0 || dut.r_pend !== 1'b1) begin
      errors++;
      $display("FAIL coll_nocap: got occ=%0d v=%b pend=%b expected 0/0/1",
               dut.r_occ, m_valid, dut.r_pend);
    end
    cyc(1);
    wait_drain();
    checks++;
    if (xfer_cnt !== 16'd7) begin
      errors++;
      $display("FAIL coll_total: got %0d expected 7", xfer_cnt);
    end
  endtask

  task automatic test_enable;
    do_reset();
    for (int i = 0; i < 6; i++) drive_wr(8'h60 + 8'(i));
    en      = 1'b1;
    m_ready = 1'b0;
    cyc(4);
    checks++;
    if (dut.r_occ !== 2'd2 || f_cnt !== 5'd4) begin
      errors++;
      $display("FAIL en_full: got occ=%0d fifo=%0d expected 2/4", dut.r_occ, f_cnt);
    end
    en      = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd !== 1'b0 || m_valid !== (c < 2)) begin
        errors++;
        $display("FAIL en_gate c=%0d: got rd=%b v=%b expected 0/%b", c, fifo_rd, m_valid, c < 2);
      end
    end
    cyc(1);
    en = 1'b1;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: got %b expected 1", fifo_rd);
    end
    wait_drain();
    checks++;
    if (xfer_cnt !== 16'd6) begin
      errors++;
      $display("FAIL en_total: got %0d expected 6", xfer_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] cnt_log[$];
    do_reset();
    for (int i = 0; i < 16; i++) drive_wr(8'h80 + 8'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        fifo_wr    = 1'b1;
        fifo_wdata = 8'h9F;
        exp_q.push_back(8'h9F);
      end else begin
        fifo_wr = 1'b0;
      end
      @(negedge clk);
      if (m_valid && m_ready) cnt_log.push_back(xfer_cnt4);
    end
    checks++;
    if (cnt_log.size() != 17) begin
      errors++;
      $display("FAIL wrap_count: got %0d handshakes expected 17", cnt_log.size());
    end else begin
      checks++;
      if (cnt_log[15] !== 4'd15 || cnt_log[16] !== 4'd0 || xfer_cnt4 !== 4'd1) begin
        errors++;
        $display("FAIL wrap_seq: got %0d,%0d,%0d expected 15,0,1",
                 cnt_log[15], cnt_log[16], xfer_cnt4);
      end
    end
    checks++;
    if (xfer_cnt !== 16'd17) begin
      errors++;
      $display("FAIL wrap_wide: got %0d expected 17", xfer_cnt);
    end
    cyc(1);
    wait_drain();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_collision();
    test_enable();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the 16-entry byte FIFO. It pops words through the FIFO's `rd`/`dout`/`empty` port and presents them, in order, on a valid/ready master stream. A 2-entry output buffer absorbs the FIFO's one-cycle read latency so the stream runs back-to-back at one word per cycle. It sits between the FIFO and any downstream consumer, such as a serializer or checker.

## Interface
- `DW`, 8, data width; matches the FIFO `dout` width.
- `CW`, 16, width of the transfer counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables issuing new FIFO reads; buffered data drains regardless.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  in  1  copy of the FIFO write strobe, used to detect dropped reads.
- `fifo_dout`  in  DW  FIFO read data; valid the cycle after an honored read.
- `fifo_rd`  out  1  FIFO read strobe; combinational.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DW  output word (buffer head).
- `xfer_cnt`  out  CW  count of completed output handshakes.

## Operation
- State: `buf[0:1]` (DW each), `occ` (0..2), `pend` (1 bit: a read was honored last cycle), `xfer_cnt`.
- `deq` = `m_valid & m_ready`.
- Read issue: `fifo_rd` = `rst_n & en & !fifo_empty & ((occ + pend - deq) < 2)`.
  - This gives a combinational path from `m_ready` to `fifo_rd`.
- The FIFO gives write priority over read. Therefore `honored` = `fifo_rd & !(fifo_wr & !fifo_full)`.
  - A dropped read has no effect on state and is simply re-issued on a later cycle.
- Each edge:
  - `pend` <= `honored`.
  - If `pend`, `fifo_dout` is written to the buffer tail.
  - If `deq`, the head is popped.
  - `occ` <= `occ + pend - deq`.
  - Simultaneous capture and pop is legal, including at `occ` = 2. The pop frees the head; the capture goes into the freed slot, preserving order.
- `m_valid` = (`occ` != 0). `m_data` = head entry.
- `m_valid`/`m_data` must stay stable while `m_valid & !m_ready`.
- Invariant: `occ + pend` <= 2. Buffer overflow is impossible by construction; a bench assertion checks it.
- `xfer_cnt` increments on every `deq` and wraps from 2^CW-1 to 0.
- `en` low: no new reads are issued. An already-honored read still captures, and the buffer keeps draining.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `occ` = 0, `pend` = 0, buffer contents = 0.
  - `m_valid` = 0, `m_data` = 0, `xfer_cnt` = 0.
  - `fifo_rd` = 0 (gated by `rst_n`).
- Latency: an honored `fifo_rd` in cycle N makes the FIFO register `dout` at edge N. The word is captured at edge N+1, and `m_valid` rises in cycle N+2.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd` and `deq` are high every cycle in steady state (`occ` = 1, `pend` = 1).
- Backpressure: when `m_ready` drops, at most one more word is captured, `occ` reaches 2, and `fifo_rd` deasserts the same cycle `occ + pend - deq` reaches 2.
- Reset mid-operation:
  - Buffered and pending words are discarded. The in-flight `fifo_dout` is not captured.
  - The FIFO itself is not affected.
  - After `rst_n` rises, the first `fifo_rd` can assert in the first cycle.
- Empty boundary: `fifo_rd` never asserts while `fifo_empty` = 1, including the cycle the FIFO empties on the previous read.

## Test plan
- Reset: assert `rst_n` = 0 asynchronously mid-cycle. Require:
  - `m_valid` = 0, `m_data` = 0x00, `xfer_cnt` = 0, `fifo_rd` = 0 without waiting for a clock edge.
  - These values held until release.
- Streaming: FIFO preloaded with 0x00..0x0F, `en` = 1, `m_ready` = 1. Require:
  - `fifo_rd` high for 16 consecutive cycles.
  - `m_data` = 0x00..0x0F on 16 consecutive cycles, the first arriving 2 cycles after the first `fifo_rd`.
  - Final `xfer_cnt` = 16, `fifo_empty` = 1, `m_valid` = 0.
- Backpressure: stream 8 bytes and hold `m_ready` = 0 from the 3rd word. Require:
  - `occ` = 2 and `fifo_rd` = 0 while stalled.
  - FIFO count drops by exactly 4 in total (2 delivered plus 2 buffered).
  - `m_data` stays stable at the 3rd word.
  - After release, the remaining words arrive in order with no duplicates.
- Write collision: drive `fifo_wr` = 1 with `fifo_full` = 0 on the same cycle as `fifo_rd`. Require:
  - No capture 1 cycle later, and `pend` = 0.
  - The read is re-issued.
  - The delivered sequence has no loss or duplicate versus a reference queue.
- Enable gating: `en` = 0 with a non-empty FIFO and a full buffer. Require:
  - `fifo_rd` = 0 throughout.
  - The buffer drains 2 words, then `m_valid` = 0.
  - Re-asserting `en` resumes reads.
- Counter wrap: with CW = 4, stream 17 words. Require `xfer_cnt` to go 15 → 0 → 1.
